// File: rtl/srt_div_iter.sv
// rtl/srt_div_iter.sv - radix-2 SRT mantissa-division iteration engine
//
// Holds the partial remainder, divisor and quotient for one single-precision
// mantissa division and runs ITER iterations. Each cycle the registered
// remainder/divisor go out to the external digit-selection stage. The digit
// code that comes back is then used to update the remainder and the quotient.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake (accepted only in IDLE)
//   dividend, divisor   normalized mantissas, 1.23 format
//   current_remainder   registered partial remainder r to digit selection
//   current_divisor     registered zero-extended divisor d to digit selection
//   rounding_data       digit code from digit selection: sign-extended q << 2
//   out_valid/out_ready result handshake
//   quotient            Q, with X/D = Q / 2^(ITER-1)
//   sticky              final remainder nonzero
//   div_err             divisor not normalized, result forced to zero
//   dsel_err            illegal digit code seen during this division
module srt_div_iter #(
    parameter int MW   = 24,
    parameter int RW   = 26,
    parameter int ITER = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MW-1:0]   dividend,
    input  logic [MW-1:0]   divisor,
    output logic [RW-1:0]   current_remainder,
    output logic [RW-1:0]   current_divisor,
    input  logic [MW-1:0]   rounding_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ITER-1:0] quotient,
    output logic            sticky,
    output logic            div_err,
    output logic            dsel_err
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q;
    logic [RW-1:0]   rem_q, rem_d;
    logic [RW-1:0]   dvs_q, dvs_d;
    logic [ITER-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div_err_q, div_err_d;
    logic            dsel_err_q, dsel_err_d;

    logic [2:0]      q_code;
    logic [RW-1:0]   q_rw;
    logic [ITER-1:0] q_acc;
    logic [RW-1:0]   qd;
    logic            code_bad;
    logic            accept;

    assign q_code = rounding_data[4:2];

    // Remainder and quotient updates are done in two's-complement arithmetic
    // modulo 2^RW and 2^ITER respectively. Truncating the wider signed
    // results gives exactly these bits, so the extra guard bits never need
    // to be materialised.
    assign q_rw  = {{(RW-3){q_code[2]}}, q_code};
    assign q_acc = {{(ITER-3){q_code[2]}}, q_code};
    assign qd    = q_rw * dvs_q;

    // Legal codes: low two bits zero, digit in -3..2, upper bits a clean
    // sign extension of bit 4.
    assign code_bad = (rounding_data[1:0] != 2'b00)
                   || (q_code == 3'b100)
                   || (q_code == 3'b011)
                   || (rounding_data[MW-1:5] != {(MW-5){rounding_data[4]}});

    assign accept = in_valid && in_ready;

    // ready_q keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            rem_q      <= '0;
            dvs_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            div_err_q  <= 1'b0;
            dsel_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            div_err_q  <= div_err_d;
            dsel_err_q <= dsel_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        div_err_d  = div_err_q;
        dsel_err_d = dsel_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d      = '0;
                    cnt_d      = '0;
                    dsel_err_d = 1'b0;
                    dvs_d      = {{(RW-MW){1'b0}}, divisor};
                    if (divisor[MW-1]) begin
                        rem_d     = {{(RW-MW){1'b0}}, dividend};
                        div_err_d = 1'b0;
                        state_d   = S_ITER;
                    end else begin
                        // Zero remainder makes sticky read 0 for the error result.
                        rem_d     = '0;
                        div_err_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_ITER: begin
                // r <= 2*(r - q*d); an illegal code is still applied as decoded.
                rem_d = (rem_q - qd) << 1;
                acc_d = (acc_q << 1) + q_acc;
                cnt_d = cnt_q + 1'b1;
                if (code_bad) begin
                    dsel_err_d = 1'b1;
                end
                if (cnt_q == CW'(ITER-1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready          = ready_q && (state_q == S_IDLE);
    assign out_valid         = (state_q == S_DONE);
    assign quotient          = acc_q;
    assign sticky            = |rem_q;
    assign div_err           = div_err_q;
    assign dsel_err          = dsel_err_q;
    assign current_remainder = rem_q;
    assign current_divisor   = dvs_q;

endmodule

// File: tb/tb_srt_div_iter.sv
// tb/tb_srt_div_iter.sv - scoreboard bench for srt_div_iter
module tb_srt_div_iter;

    localparam int MW   = 24;
    localparam int RW   = 26;
    localparam int ITER = 26;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [MW-1:0]   dividend;
    logic [MW-1:0]   divisor;
    logic [RW-1:0]   current_remainder;
    logic [RW-1:0]   current_divisor;
    logic [MW-1:0]   rounding_data;
    logic            out_valid;
    logic            out_ready;
    logic [ITER-1:0] quotient;
    logic            sticky;
    logic            div_err;
    logic            dsel_err;

    int total = 0;
    int bad   = 0;

    int          sel_mode  = 0;
    logic        force_en  = 1'b0;
    logic [MW-1:0] force_val = '0;

    typedef struct packed {
        logic [ITER-1:0] q;
        logic            st;
        logic            de;
        logic            dse;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    srt_div_iter #(.MW(MW), .RW(RW), .ITER(ITER)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .dividend          (dividend),
        .divisor           (divisor),
        .current_remainder (current_remainder),
        .current_divisor   (current_divisor),
        .rounding_data     (rounding_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .quotient          (quotient),
        .sticky            (sticky),
        .div_err           (div_err),
        .dsel_err          (dsel_err)
    );

    // Digit-selection stage. Mode 0: restoring digits {0,1}. Mode 1: SRT digits {-1,0,1}.
    logic signed [RW-1:0] sel_r, sel_d;
    logic signed [2:0]    sel_q;
    always_comb begin
        sel_r = current_remainder;
        sel_d = current_divisor;
        sel_q = 3'sd0;
        if (sel_r >= sel_d) sel_q = 3'sd1;
        else if (sel_mode == 1 && sel_r < -sel_d) sel_q = -3'sd1;
        rounding_data = force_en ? force_val : ({{(MW-3){sel_q[2]}}, sel_q} << 2);
    end

    function automatic exp_t mk(input logic [ITER-1:0] q, input logic st, input logic de, input logic dse);
        exp_t e;
        e.q = q; e.st = st; e.de = de; e.dse = dse;
        return e;
    endfunction

    // Reference: X/D = Q/2^25 with X*2^26 = 2*D*Q + r_final.
    function automatic exp_t model(input logic [MW-1:0] x, input logic [MW-1:0] d, input int mode);
        exp_t   e;
        longint xl, dl, n, r, qv, qq;
        e  = '0;
        xl = longint'(x);
        dl = longint'(d);
        if (!d[MW-1]) begin
            e.de = 1'b1;
            return e;
        end
        if (mode == 0) begin
            n    = xl << (ITER-1);
            qv   = n / dl;
            e.q  = qv[ITER-1:0];
            e.st = (n % dl) != 0;
        end else begin
            r  = xl;
            qv = 0;
            for (int i = 0; i < ITER; i++) begin
                if (r >= dl) qq = 1;
                else if (r < -dl) qq = -1;
                else qq = 0;
                r  = 2 * (r - qq * dl);
                qv = 2 * qv + qq;
            end
            e.q  = qv[ITER-1:0];
            e.st = (r != 0);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every result handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("quotient", 64'(quotient), 64'(mon_e.q));
                check("sticky",   64'(sticky),   64'(mon_e.st));
                check("div_err",  64'(div_err),  64'(mon_e.de));
                check("dsel_err", 64'(dsel_err), 64'(mon_e.dse));
            end
        end
    end

    task automatic issue(input logic [MW-1:0] x, input logic [MW-1:0] d, input int mode);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        dividend = x;
        divisor  = d;
        sel_mode = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [MW-1:0] x, input logic [MW-1:0] d, input int mode,
                           input int stall, input exp_t e, output int lat);
        exp_q.push_back(e);
        out_ready = (stall == 0);
        issue(x, d, mode);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        check("out_valid_seen", 64'(out_valid), 64'd1);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [MW-1:0] codes [5] = '{24'h000001, 24'h00000C, 24'h000020, 24'hFFFFF0, 24'hFFFFF4};
    logic          code_err [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int   lat;
        int   guard;
        exp_t e;
        logic [MW-1:0] x, d;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dividend = '0; divisor = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient",  64'(quotient), 64'd0);
        check("rst_sticky",    64'(sticky), 64'd0);
        check("rst_div_err",   64'(div_err), 64'd0);
        check("rst_dsel_err",  64'(dsel_err), 64'd0);
        check("rst_cur_rem",   64'(current_remainder), 64'd0);
        check("rst_cur_div",   64'(current_divisor), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_clk", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_clk", 64'(in_ready), 64'd1);

        // Directed divisions
        run_one(24'h800000, 24'h800000, 0, 0, mk(26'h2000000, 1'b0, 1'b0, 1'b0), lat);
        check("latency_legal", 64'(lat), 64'd27);
        run_one(24'hC00000, 24'h800000, 0, 0, mk(26'h3000000, 1'b0, 1'b0, 1'b0), lat);
        run_one(24'h800000, 24'hC00000, 0, 0, mk(26'h1555555, 1'b1, 1'b0, 1'b0), lat);
        run_one(24'h800000, 24'h400000, 0, 0, mk(26'h0, 1'b0, 1'b1, 1'b0), lat);
        check("latency_div_err", 64'(lat), 64'd1);
        run_one(24'hFFFFFF, 24'h800000, 1, 0, mk(26'h3FFFFFC, 1'b0, 1'b0, 1'b0), lat);

        // Back-pressure: hold out_ready low while pulsing in_valid
        e = model(24'hA00000, 24'hE00000, 0);
        exp_q.push_back(e);
        out_ready = 1'b0;
        issue(24'hA00000, 24'hE00000, 0);
        guard = 0;
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("hold_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 in_valid = i[0];
            dividend = 24'h800000 | 24'($urandom);
            divisor  = 24'h800000 | 24'($urandom);
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready), 64'd0);
            check("hold_quotient",  64'(quotient), 64'(e.q));
            check("hold_sticky",    64'(sticky), 64'(e.st));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        in_valid = 1'b1;
        dividend = 24'h900000;
        divisor  = 24'h800000;
        exp_q.push_back(model(24'h900000, 24'h800000, 0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_hs_in_ready",  64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_quotient",  64'(quotient), 64'(e.q));
        @(posedge clk);
        #1 in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("next_valid_seen", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Forced digit codes at iteration 5, reset at iteration 12
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b1;
            issue(24'h800000, 24'h800000, 0);
            repeat (4) @(posedge clk);
            #1 force_val = codes[k];
            force_en = 1'b1;
            @(posedge clk);
            #1 force_en = 1'b0;
            @(negedge clk);
            check("dsel_err_flag", 64'(dsel_err), 64'(code_err[k]));
            repeat (6) @(posedge clk);
            #1 rst_n = 1'b0;
            @(negedge clk);
            check("abort_out_valid", 64'(out_valid), 64'd0);
            check("abort_dsel_err",  64'(dsel_err), 64'd0);
            check("abort_quotient",  64'(quotient), 64'd0);
            check("abort_sticky",    64'(sticky), 64'd0);
            check("abort_cur_rem",   64'(current_remainder), 64'd0);
            check("abort_in_ready",  64'(in_ready), 64'd0);
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
        run_one(24'h800000, 24'h800000, 0, 0, mk(26'h2000000, 1'b0, 1'b0, 1'b0), lat);
        check("latency_post_reset", 64'(lat), 64'd27);

        // Randomized divisions
        for (int n = 0; n < 40; n++) begin
            int mode;
            int stall;
            x = 24'($urandom) | 24'h800000;
            d = 24'($urandom) | 24'h800000;
            if ($urandom_range(0, 7) == 0) d[MW-1] = 1'b0;
            mode  = int'($urandom_range(0, 1));
            stall = int'($urandom_range(0, 3));
            run_one(x, d, mode, stall, model(x, d, mode), lat);
        end

        @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/srt_div_iter.md
Name: srt_div_iter

Overview:
- Sequential radix-2 SRT mantissa-division iteration engine for the single-precision divider.
- Holds the partial remainder, divisor and quotient registers, and sequences the iterations.
- Drives the existing combinational digit-selection stage each cycle through current_remainder/current_divisor, then consumes the returned rounding_data code to update the remainder and the quotient.
- Sits between operand unpack (upstream) and normalize/round (downstream).

Parameters:
- MW, 24, mantissa width including hidden bit.
- RW, 26, remainder/divisor bus width (two's complement); must equal MW+2.
- ITER, 26, quotient digits produced per division.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept operands.
- dividend  in  MW  normalized mantissa X, 1.23 format.
- divisor  in  MW  normalized mantissa D, 1.23 format; bit MW-1 must be 1.
- current_remainder  out  RW  registered partial remainder r, to the digit-selection stage.
- current_divisor  out  RW  registered D, zero-extended, to the digit-selection stage.
- rounding_data  in  MW  digit code from the digit-selection stage: sign-extended digit q shifted left 2.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  ITER  unsigned quotient Q; X/D = Q / 2^(ITER-1).
- sticky  out  1  final remainder nonzero.
- div_err  out  1  divisor not normalized; result forced to zero.
- dsel_err  out  1  illegal digit code seen during this division.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all registers zero. in_ready=0 while in reset, 1 from the first clock after release. out_valid, quotient, sticky, div_err, dsel_err, current_remainder and current_divisor all 0.
- States are IDLE, ITER and DONE.
- IDLE: in_ready=1.
  - On in_valid with divisor[MW-1]=1: load r=zero-extended dividend, d=divisor, Q=0, cnt=0, clear dsel_err, then go to ITER.
  - On in_valid with divisor[MW-1]=0: set div_err=1, Q=0, sticky=0, then go to DONE.
- ITER: in_ready=0. Each cycle, decode q = signed rounding_data[4:2].
  - Update r <= 2*(r - q*d), computed in RW+2 signed bits and truncated to RW.
  - Update Q <= 2*Q + q, kept as an internal ITER+2 bit signed accumulator.
  - Increment cnt.
  - After the ITER-th update (cnt = ITER-1), go to DONE.
  - dsel_err rule: if rounding_data[1:0] != 0, or q is outside -3..2, or rounding_data[MW-1:5] is not the sign extension of bit 4, set dsel_err=1 (sticky until the next accept). Still apply q as decoded; no stall.
- DONE: out_valid=1. quotient = Q[ITER-1:0], which is always non-negative for legal inputs. sticky = (r != 0).
  - Hold all outputs stable until out_ready=1.
  - In that handshake cycle return to IDLE. out_valid drops the next cycle; quotient, sticky, div_err and dsel_err hold their values until the next accept.
- Latency, legal divisor: accept at edge 0, ITER iteration edges, out_valid high from the cycle after the last iteration. Total ITER+1 cycles from accept to out_valid.
- Latency, div_err case: out_valid in the cycle after accept.
- Throughput: one division per ITER+2 cycles with out_ready held high. A new accept is possible only in IDLE, so no overlap.
- current_remainder and current_divisor are driven directly from registers, with no combinational path from rounding_data.
- in_valid while not in IDLE is ignored (in_ready=0); the operands must be held by the producer.
- Reset asserted mid-ITER or mid-DONE aborts immediately and returns to the reset values above; no result is emitted.
- Range invariant: for legal inputs, |r| < 3d at every iteration, so q*d fits RW+2 bits.

Test Plan:
- X=0x800000, D=0x800000 -> q sequence 1,0,0,…; quotient=0x2000000, sticky=0, out_valid exactly 27 cycles after accept.
- X=0xC00000, D=0x800000 -> quotient=0x3000000, sticky=0, div_err=0, dsel_err=0.
- X=0x800000, D=0xC00000 -> quotient=0x1555555, sticky=1.
- D=0x400000 (unnormalized) -> out_valid the cycle after accept; div_err=1, quotient=0, sticky=0.
- Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, no new accept; a new accept is possible in the cycle after out_ready=1.
- Force rounding_data=0x000001 at iteration 5, then pulse rst_n=0 at iteration 12 -> dsel_err=1 before the reset; after the reset all outputs are 0 and the next division (1.0/1.0) is correct with dsel_err=0.
